wave_trace_render: RTL



---
 rtl/wave_trace_render.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/wave_trace_render.sv
// wave_trace_render: reader/display end of the 1024x8 AD capture buffer.
// Pixel (x,y) presented on pixel_xpos/pixel_ypos at cycle t becomes
// pixel_data at t+3: rd_addr is registered at t+1, the RAM answers at t+2
// and the pixel colour is registered at t+3. Window flags follow the same
// two-stage delay so that they line up with rd_data.
// Optional feature macro: GRID_EN (draws an 8x4 division grid in the window).
module wave_trace_render #(
    parameter int          WIN_X0     = 448,
    parameter int          WIN_Y0     = 200,
    parameter logic [23:0] TRACE_RGB  = 24'hFFFF00,
    parameter logic [23:0] BORDER_RGB = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB     = 24'h000000
) (
    input  logic        pixel_clk,
    input  logic        sys_rst,
    input  logic [11:0] pixel_xpos,
    input  logic [11:0] pixel_ypos,
    input  logic        cap_done,
    output logic [9:0]  rd_addr,
    input  logic [7:0]  rd_data,
    output logic        buf_busy,
    output logic [23:0] pixel_data
);

    localparam logic [11:0] X_LO = 12'(WIN_X0);
    localparam logic [11:0] X_HI = 12'(WIN_X0 + 1023);
    localparam logic [11:0] Y_LO = 12'(WIN_Y0);
    localparam logic [11:0] Y_HI = 12'(WIN_Y0 + 255);
`ifdef GRID_EN
    localparam logic [23:0] GRID_RGB = 24'h404040;
`endif

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_DRAW       = 2'd2
    } state_t;

    // Smaller / larger of two samples; bounds of the vertical line segment.
    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        if (a < b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    state_t      state_r;

    // Stage 0 (combinational view of the requested pixel)
    logic [11:0] dx_s;
    logic [11:0] dy_s;
    logic        in_x_s;
    logic        in_y_s;
    logic        in_win_s;
    logic        on_edge_s;
    logic        border_s;
    logic        col0_s;
    logic [7:0]  level_s;
    logic [9:0]  addr_s;
    logic        frame_start_s;
    logic        last_px_s;
    logic        draw_s;

    // Stage 1 (aligned with rd_addr)
    logic        in_win1_r;
    logic        border1_r;
    logic        col01_r;
    logic [7:0]  level1_r;
    logic        draw1_r;

    // Stage 2 (aligned with rd_data)
    logic        in_win2_r;
    logic        border2_r;
    logic        col02_r;
    logic [7:0]  level2_r;
    logic        draw2_r;

    // Line fill
    logic [7:0]  prev_r;
    logic [7:0]  prev_eff_s;
    logic [7:0]  lo_s;
    logic [7:0]  hi_s;
    logic        hit_s;
    logic [23:0] color_s;

`ifdef GRID_EN
    logic        grid_s;
    logic        grid1_r;
    logic        grid2_r;
`endif

    // Decode the requested pixel against the window; unsigned 12-bit compares.
    always_comb begin
        dx_s          = pixel_xpos - X_LO;
        dy_s          = pixel_ypos - Y_LO;
        in_x_s        = (pixel_xpos >= X_LO) && (pixel_xpos <= X_HI);
        in_y_s        = (pixel_ypos >= Y_LO) && (pixel_ypos <= Y_HI);
        in_win_s      = in_x_s && in_y_s;
        on_edge_s     = (dx_s == 12'd0) || (dx_s == 12'd1023) ||
                        (dy_s == 12'd0) || (dy_s == 12'd255);
        border_s      = in_win_s && on_edge_s;
        col0_s        = in_x_s && (dx_s == 12'd0);
        // Row 0 of the window is level 255, the bottom row is level 0.
        level_s       = 8'd255 - dy_s[7:0];
        if (in_x_s) begin
            addr_s = dx_s[9:0];
        end else begin
            addr_s = 10'd0;
        end
        frame_start_s = (pixel_xpos == 12'd0) && (pixel_ypos == 12'd0);
        last_px_s     = (pixel_xpos == X_HI) && (pixel_ypos == Y_HI);
        draw_s        = (state_r == S_DRAW);
    end

`ifdef GRID_EN
    // Grid lines every 128 columns and every 64 rows inside the window.
    always_comb begin
        grid_s = in_win_s && ((dx_s[6:0] == 7'd0) || (dy_s[5:0] == 6'd0));
    end
`endif

    // Capture/draw handshake FSM; buf_busy covers S_DRAW plus the pipeline tail.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state_r  <= S_IDLE;
            buf_busy <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cap_done) begin
                        state_r <= S_WAIT_FRAME;
                    end else begin
                        state_r <= S_IDLE;
                    end
                    buf_busy <= draw1_r;
                end
                S_WAIT_FRAME: begin
                    if (frame_start_s) begin
                        state_r  <= S_DRAW;
                        buf_busy <= 1'b1;
                    end else begin
                        state_r  <= S_WAIT_FRAME;
                        buf_busy <= draw1_r;
                    end
                end
                S_DRAW: begin
                    if (last_px_s) begin
                        state_r <= S_WAIT_FRAME;
                    end else begin
                        state_r <= S_DRAW;
                    end
                    // The last window pixel is still in flight for two more cycles.
                    buf_busy <= 1'b1;
                end
                default: begin
                    state_r  <= S_IDLE;
                    buf_busy <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: register the RAM address and the pixel's window attributes.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            rd_addr   <= 10'd0;
            in_win1_r <= 1'b0;
            border1_r <= 1'b0;
            col01_r   <= 1'b0;
            level1_r  <= 8'd0;
            draw1_r   <= 1'b0;
        end else begin
            rd_addr   <= addr_s;
            in_win1_r <= in_win_s;
            border1_r <= border_s;
            col01_r   <= col0_s;
            level1_r  <= level_s;
            draw1_r   <= draw_s;
        end
    end

    // Stage 2: delay the attributes so they meet rd_data.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            in_win2_r <= 1'b0;
            border2_r <= 1'b0;
            col02_r   <= 1'b0;
            level2_r  <= 8'd0;
            draw2_r   <= 1'b0;
        end else begin
            in_win2_r <= in_win1_r;
            border2_r <= border1_r;
            col02_r   <= col01_r;
            level2_r  <= level1_r;
            draw2_r   <= draw1_r;
        end
    end

`ifdef GRID_EN
    // Grid flag travels through the same two-stage delay.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            grid1_r <= 1'b0;
            grid2_r <= 1'b0;
        end else begin
            grid1_r <= grid_s;
            grid2_r <= grid1_r;
        end
    end
`endif

    // Line fill: the trace spans every level between this sample and its left neighbour.
    always_comb begin
        if (col02_r) begin
            prev_eff_s = rd_data;
        end else begin
            prev_eff_s = prev_r;
        end
        lo_s  = min8(prev_eff_s, rd_data);
        hi_s  = max8(prev_eff_s, rd_data);
        hit_s = (level2_r >= lo_s) && (level2_r <= hi_s);
    end

    // Pixel priority: outside, border, trace, grid, background.
    always_comb begin
        if (!in_win2_r) begin
            color_s = BG_RGB;
        end else if (border2_r) begin
            color_s = BORDER_RGB;
        end else if (draw2_r && hit_s) begin
            color_s = TRACE_RGB;
`ifdef GRID_EN
        end else if (grid2_r) begin
            color_s = GRID_RGB;
`endif
        end else begin
            color_s = BG_RGB;
        end
    end

    // Stage 3: register the colour and remember this column's sample for the next one.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            pixel_data <= BG_RGB;
            prev_r     <= 8'd0;
        end else begin
            pixel_data <= color_s;
            if (in_win2_r) begin
                prev_r <= rd_data;
            end else begin
                prev_r <= prev_r;
            end
        end
    end

endmodule
